uart_tx: RTL and testbench
==========================

# uart_tx

Byte-oriented UART transmitter, 8N1 framing, LSB first, with a small input FIFO. It sits between the trading core's output logic (order and signal bytes) and the board's serial TX pin. It shares baud parameters with the receive path so both directions run at the same line rate. Upstream pushes bytes with a valid/ready handshake; the block serialises them back-to-back with no idle gap while the FIFO holds data.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, truncated), must be ≥ 2
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  8  byte to transmit
- data_valid  input  1  data_in is valid this cycle
- ready  output  1  FIFO can accept a byte (not full); a push occurs on an edge where data_valid && ready
- tx  output  1  serial line, registered, idle high
- busy  output  1  high when a frame is in progress or the FIFO is non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO, excluding the byte being shifted

## Operation
- Reset values (async, while rst=1): tx=1, ready=1, busy=0, fifo_count=0, FSM=IDLE, bit counter=0, baud counter=0, FIFO pointers=0.
- Reset mid-frame aborts the frame immediately. tx returns high asynchronously and the FIFO contents are discarded.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. ready = (fifo_count != FIFO_DEPTH), computed from the registered count.
  - A push while full is ignored, even if a pop occurs on the same edge.
  - A push and pop on the same edge leave fifo_count unchanged.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, drive tx=0, clear the baud counter, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then drive tx=shift[0], bit index=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. After bit 7, drive tx=1 and go to STOP. Otherwise shift right, output the next bit, and increment the index.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty, pop and go directly to START with tx=0 on that same edge. There is no extra idle cycle.
    - Otherwise go to IDLE.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and the bit period ends when count == CLKS_PER_BIT-1. No drift accumulates across frames.
- busy = (state != IDLE) || (fifo_count != 0). It is registered-equivalent, with no combinational path from data_valid.

## Timing
- Push accepted on edge E: fifo_count increments after E. If the FSM was IDLE, tx falls after edge E+1, so the start bit begins one cycle after acceptance.
- Frame length: exactly 10 × CLKS_PER_BIT cycles (1 start, 8 data, 1 stop) from the tx falling edge to the next possible start.
- Back-to-back bytes: the next start bit begins exactly 10 × CLKS_PER_BIT cycles after the previous start bit.
- ready may deassert the cycle after the edge that fills the FIFO. It reasserts the cycle after the pop that frees a slot.
- data_in is sampled only on accepting edges. Values at other times are don't-care.
- The pop happens when a frame starts, so fifo_count drops at the start bit, not at the end of the frame.

## Test plan
Use CLK_FREQ=1000 and BAUD_RATE=100 (10 clks/bit), FIFO_DEPTH=4, unless noted.
- Single byte 0xA5 pushed on edge E -> tx low from E+1 for 10 cycles. Data bits are 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high for 10 cycles. busy drops after the stop bit. Total 100 cycles.
- Bytes 0x00, 0xFF, 0x55 pushed on consecutive cycles -> three frames contiguous, with start bits exactly 100 cycles apart and no idle gap. fifo_count goes 1,1,2 then decrements at each start bit.
- Push 6 bytes with data_valid held high -> ready drops once 4 bytes are queued behind the active frame, and extra pushes are ignored. Each transmitted byte matches, in order, the bytes accepted while ready=1.
- Assert rst at cycle 35 of a 0x3C frame -> tx=1, busy=0, fifo_count=0, ready=1 immediately. After release, pushing 0x81 produces a clean frame starting one cycle after acceptance.
- Simultaneous push and pop: FIFO holding 1 byte, push on the STOP→START edge -> fifo_count stays 1 and byte order is preserved.
- Loopback of tx into uart_rx with default parameters (100 MHz, 9600): bytes 0x00..0xFF are all received intact.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte push channel into the UART transmitter: valid/ready handshake with an 8-bit payload.
// The upstream producer owns data_in/data_valid and the transmitter answers with ready.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small circular FIFO.
// Queued bytes are serialised back-to-back: the next start bit follows the stop bit with no idle cycle.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_if.slave                    up,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic baud_end;
  logic push;
  logic pop;
  logic fifo_empty;

  // ready comes straight from the registered count, so it never depends on data_valid.
  assign up.ready   = (fifo_count != CNT_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign push       = up.data_valid && up.ready;
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign busy       = (state != IDLE) || !fifo_empty;

  // NOTE: the storage array has no reset; a slot is only read after a push has written it,
  // and leaving it out keeps the array mappable to plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up.data_in;
  end

  // Pointers wrap for free because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: all state here is updated with nonblocking assignments so every branch reads the
  // pre-edge values of shift/baud_cnt, which is what the tx <= shift[1] look-ahead relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit, FIFO depth 4.
// Expected line waveforms are computed from the 8N1 frame rule; FIFO occupancy from a queue model.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int total  = 0;
  int passed = 0;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (bus),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks frame samples k in [first_k, last_k); sample k is the line value k cycles after the start bit began.
  // At k==0 the FIFO occupancy is also checked when exp_cnt >= 0.
  task automatic frame(input logic [7:0] b, input int first_k, input int last_k, input int exp_cnt);
    logic e;
    for (int k = first_k; k < last_k; k++) begin
      if (k < 10)      e = 1'b0;
      else if (k < 90) e = b[3'((k - 10) / 10)];
      else             e = 1'b1;
      check($sformatf("tx_%02h_k%0d", b, k), 32'(tx), 32'(e));
      if (k == 0 && exp_cnt >= 0) begin
        check($sformatf("cnt_start_%02h", b), 32'(fifo_count), 32'(exp_cnt));
        check($sformatf("ready_start_%02h", b), 32'(bus.ready), 32'(exp_cnt != 4));
      end
      @(negedge clk);
    end
  endtask

  // Push one byte into an idle transmitter and check the whole frame plus the return to idle.
  task automatic send_single(input logic [7:0] b);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check("single_cnt", 32'(fifo_count), 32'd1);
    check("single_tx_pre", 32'(tx), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    frame(b, 0, 100, 0);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_tx_end", 32'(tx), 32'd1);
  endtask

  logic [7:0] q[$];
  logic [7:0] b, ba, bb, bc;
  int  mc;
  bit  started, push_ok, pop_ok;

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5
    send_single(8'hA5);

    // Three bytes on consecutive cycles: contiguous frames 100 cycles apart
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h00;
    @(negedge clk);
    check("b2b_cnt0", 32'(fifo_count), 32'd1);
    check("b2b_tx_pre", 32'(tx), 32'd1);
    bus.data_in = 8'hFF;
    @(negedge clk);
    check("b2b_cnt1", 32'(fifo_count), 32'd1);
    check("b2b_tx_k0", 32'(tx), 32'd0);
    bus.data_in = 8'h55;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check("b2b_cnt2", 32'(fifo_count), 32'd2);
    frame(8'h00, 1, 100, -1);
    frame(8'hFF, 0, 100, 1);
    frame(8'h55, 0, 100, 0);
    check("b2b_busy_end", 32'(busy), 32'd0);

    // Six random bytes with data_valid held: acceptance and occupancy from a queue model
    mc = 0;
    started = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bus.data_valid = 1'b1;
      bus.data_in    = b;
      push_ok = (mc != 4);
      pop_ok  = !started && (mc != 0);
      if (push_ok) q.push_back(b);
      mc = mc + int'(push_ok) - int'(pop_ok);
      if (pop_ok) started = 1'b1;
      @(negedge clk);
      check($sformatf("burst_cnt%0d", i), 32'(fifo_count), 32'(mc));
      check($sformatf("burst_ready%0d", i), 32'(bus.ready), 32'(mc != 4));
    end
    bus.data_valid = 1'b0;
    b = q.pop_front();
    frame(b, 4, 100, -1);
    while (q.size() > 0) begin
      b = q.pop_front();
      frame(b, 0, 100, q.size());
    end
    check("burst_busy_end", 32'(busy), 32'd0);

    // Reset at cycle 35 of a 0x3C frame with a second byte queued
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h3C;
    @(negedge clk);
    bus.data_in = 8'h77;
    @(negedge clk);
    bus.data_valid = 1'b0;
    frame(8'h3C, 0, 35, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send_single(8'h81);

    // Push coinciding with the STOP->START pop keeps the count at 1 and preserves order
    ba = 8'($urandom);
    bb = 8'($urandom);
    bc = 8'($urandom);
    bus.data_valid = 1'b1;
    bus.data_in    = ba;
    @(negedge clk);
    bus.data_in = bb;
    @(negedge clk);
    bus.data_valid = 1'b0;
    frame(ba, 0, 99, 1);
    bus.data_valid = 1'b1;
    bus.data_in    = bc;
    check("pp_tx_k99", 32'(tx), 32'd1);
    @(negedge clk);
    bus.data_valid = 1'b0;
    frame(bb, 0, 100, 1);
    frame(bc, 0, 100, 0);
    check("pp_busy_end", 32'(busy), 32'd0);

    // A few more random single bytes
    for (int i = 0; i < 3; i++) begin
      send_single(8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
